proc_trace_buffer: RTL and testbench

- Parametrised on-chip execution trace for the proc core.
- Captures one entry per retired instruction (op_code, alu_out, destination) into a circular buffer, then drains the entries over a valid/ready port, oldest first.
- Capture modes: wrap, fill-and-stop, and opcode trigger with post-trigger count.
- Sits beside proc at SoC/bench level and replaces ad-hoc per-cycle logging.

---
 rtl/proc_trace_pkg.sv | 17 +
 rtl/proc_trace_mem.sv | 17 +
 rtl/proc_trace_buffer.sv | 143 ++++++++++++++
 tb/tb_proc_trace_buffer.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/proc_trace_pkg.sv
// proc_trace_pkg: shared trace modes, FSM states and entry width helper.
// PROC_TRACE_TIMESTAMP_EN widens every entry by a capture timestamp.
package proc_trace_pkg;
  localparam int OPCODE_W = 6;
  localparam int VALUE_W = 8;
  localparam int MEM_W = 5;
`ifdef PROC_TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  typedef enum logic [1:0] {WRAP = 2'd0, FILL = 2'd1, TRIG = 2'd2} trace_mode_e;
  typedef enum logic [1:0] {IDLE, CAPTURE, POST, DRAIN} trace_state_e;
  function automatic int entry_w(int ow, int vw, int mw, int tw);
    return ow + vw + mw + 2 + (TS_EN ? tw : 0);
  endfunction
endpackage

// File: rtl/proc_trace_mem.sv
// proc_trace_mem: trace entry storage, one write port, combinational read, no reset.
module proc_trace_mem #(
  parameter int DEPTH = 16,
  parameter int W = 21,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/proc_trace_buffer.sv
// proc_trace_buffer: circular execution trace with wrap, fill-stop and trigger capture, drained over valid/ready.
// Define PROC_TRACE_TIMESTAMP_EN to prefix each entry with a free-running cycle timestamp.
module proc_trace_buffer import proc_trace_pkg::*; #(
  parameter int OPCODE_WIDTH = OPCODE_W,
  parameter int VALUE_WIDTH = VALUE_W,
  parameter int MEM_WIDTH = MEM_W,
  parameter int DEPTH = 16,
  parameter int POST_TRIG = 4,
  parameter int TS_WIDTH = 16,
  localparam int ENTRY_W = entry_w(OPCODE_WIDTH, VALUE_WIDTH, MEM_WIDTH, TS_WIDTH),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  input  logic [OPCODE_WIDTH-1:0] op_code,
  input  logic [VALUE_WIDTH-1:0]  alu_out,
  input  logic [MEM_WIDTH-1:0]    dest_addr,
  input  logic [1:0]              dest_choice,
  input  logic                    arm,
  input  logic                    stop,
  input  logic [1:0]              mode,
  input  logic [OPCODE_WIDTH-1:0] trig_opcode,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [ENTRY_W-1:0]      rd_data,
  output logic                    rd_last,
  output logic [CW-1:0]           count,
  output logic                    overflow,
  output logic                    busy
);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  trace_state_e state_q, state_d;
  trace_mode_e mode_q, mode_d;
  logic [OPCODE_WIDTH-1:0] trig_q, trig_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, post_q, post_d, wr_w;
  logic [CW-1:0] count_q, count_d, rem_q, rem_d, cnt_w;
  logic ovf_q, ovf_d, rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
  logic we, trig_hit;
  logic [ENTRY_W-1:0] wdata, rdata;
`ifdef PROC_TRACE_TIMESTAMP_EN
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  assign ts_d = (state_q == IDLE && arm) ? '0 : ts_q + TS_WIDTH'(1);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ts_q <= '0;
    else ts_q <= ts_d;
  end
  assign wdata = {ts_q, op_code, alu_out, dest_choice, dest_addr};
`else
  assign wdata = {op_code, alu_out, dest_choice, dest_addr};
`endif
  assign we = cap_valid && (state_q == CAPTURE || state_q == POST);
  assign trig_hit = we && state_q == CAPTURE && mode_q == TRIG && op_code == trig_q;
  assign wr_w = we ? wr_ptr_q + AW'(1) : wr_ptr_q;
  assign cnt_w = (we && count_q != FULL) ? count_q + CW'(1) : count_q;
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    trig_d = trig_q;
    wr_ptr_d = wr_w;
    count_d = cnt_w;
    ovf_d = ovf_q || (we && count_q == FULL);
    post_d = post_q;
    rd_ptr_d = rd_ptr_q;
    rem_d = rem_q;
    rd_valid_d = rd_valid_q;
    rd_last_d = rd_last_q;
    case (state_q)
      IDLE: if (arm) begin
        state_d = CAPTURE;
        mode_d = (mode == 2'd3) ? WRAP : trace_mode_e'(mode);
        trig_d = trig_opcode;
        wr_ptr_d = '0;
        count_d = '0;
        ovf_d = 1'b0;
      end
      CAPTURE, POST: begin
        if (stop || (mode_q == FILL && cnt_w == FULL) || (trig_hit && POST_TRIG == 0)
            || (state_q == POST && we && post_q == AW'(1)))
          state_d = DRAIN;
        else if (trig_hit)
          state_d = POST;
        post_d = trig_hit ? AW'(POST_TRIG) : (state_q == POST && we) ? post_q - AW'(1) : post_q;
        // a full buffer starts at the oldest entry, which is where the next write would land
        if (state_d == DRAIN) begin
          rd_ptr_d = (cnt_w == FULL) ? wr_w : '0;
          rem_d = cnt_w;
        end
      end
      DRAIN: if (!rd_valid_q) begin
        if (rem_q == '0) state_d = IDLE;
        else begin
          rd_valid_d = 1'b1;
          rd_last_d = rem_q == CW'(1);
        end
      end else if (rd_ready) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
        rem_d = rem_q - CW'(1);
        rd_valid_d = rem_q != CW'(1);
        rd_last_d = rem_q == CW'(2);
        if (rem_q == CW'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode_q <= WRAP;
      trig_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      post_q <= '0;
      count_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      trig_q <= trig_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      post_q <= post_d;
      count_q <= count_d;
      rem_q <= rem_d;
      ovf_q <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
    end
  end
  proc_trace_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
    .clk(clk), .we(we), .waddr(wr_ptr_q), .wdata(wdata), .raddr(rd_ptr_q), .rdata(rdata)
  );
  assign rd_valid = rd_valid_q;
  assign rd_data = rd_valid_q ? rdata : '0;
  assign rd_last = rd_last_q;
  assign count = count_q;
  assign overflow = ovf_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_proc_trace_buffer.sv
// tb_proc_trace_buffer: directed scenarios against a queue-based trace model, DEPTH=4, POST_TRIG=1.
module tb_proc_trace_buffer;
  localparam int D = 4;
  localparam int P = 1;
  localparam int EW = 21;
  logic clk = 0, rst = 0, cap_valid = 0, arm = 0, stop = 0, rd_ready = 0;
  logic [5:0] op_code = 0, trig_opcode = 0;
  logic [7:0] alu_out = 0;
  logic [4:0] dest_addr = 0;
  logic [1:0] dest_choice = 0, mode = 0;
  logic rd_valid, rd_last, overflow, busy;
  logic [EW-1:0] rd_data;
  logic [2:0] count;
  int errs = 0, checks = 0;
  logic [EW-1:0] mq[$], exp_q[$];
  logic [5:0] got[$];
  bit cap_on = 0, trig_seen = 0, m_ovf = 0;
  int post_left = 0;
  logic [1:0] m_mode = 0;
  logic [5:0] m_trig = 0;

  proc_trace_buffer #(.DEPTH(D), .POST_TRIG(P)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .op_code(op_code), .alu_out(alu_out),
    .dest_addr(dest_addr), .dest_choice(dest_choice), .arm(arm), .stop(stop), .mode(mode),
    .trig_opcode(trig_opcode), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_last(rd_last), .count(count), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(logic [5:0] op);
    return {op, op, 2'b01, op[1:0], op[4:0] ^ 5'h15};
  endfunction

  always @(negedge clk) if (rst) begin
    chk("count", 32'(count), mq.size());
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (rd_valid) begin
      if (exp_q.size() == 0) chk("unexpected_rd_valid", 32'(rd_valid), 0);
      else begin
        chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
        chk("rd_last", 32'(rd_last), 32'(exp_q.size() == 1));
        if (rd_ready) begin
          got.push_back(rd_data[EW-1 -: 6]);
          void'(exp_q.pop_front());
        end
      end
    end else begin
      chk("rd_data_idle", 32'(rd_data), 0);
      chk("rd_last_idle", 32'(rd_last), 0);
    end
  end

  task automatic arm_t(logic [1:0] md, logic [5:0] tr);
    arm = 1; mode = md; trig_opcode = tr;
    @(posedge clk);
    mq.delete(); got.delete(); m_ovf = 0; cap_on = 1; trig_seen = 0;
    m_mode = md; m_trig = tr;
    #1 arm = 0;
  endtask

  task automatic retire(logic [5:0] op, bit st = 0);
    cap_valid = 1; op_code = op; alu_out = {op, 2'b01}; dest_choice = op[1:0];
    dest_addr = op[4:0] ^ 5'h15; stop = st;
    @(posedge clk);
    if (cap_on) begin
      mq.push_back(ent(op));
      if (mq.size() > D) begin void'(mq.pop_front()); m_ovf = 1; end
      if (st) cap_on = 0;
      else if (m_mode == 1 && mq.size() == D) cap_on = 0;
      else if (m_mode == 2 && !trig_seen && op == m_trig) begin
        trig_seen = 1; post_left = P;
        if (P == 0) cap_on = 0;
      end else if (trig_seen) begin
        post_left--;
        if (post_left == 0) cap_on = 0;
      end
      if (!cap_on) exp_q = mq;
    end
    #1 cap_valid = 0; stop = 0;
  endtask

  task automatic stop_t();
    stop = 1;
    @(posedge clk);
    if (cap_on) begin cap_on = 0; exp_q = mq; end
    #1 stop = 0;
  endtask

  task automatic wait_idle(string name);
    int n = 0;
    while (busy && n < 60) begin @(posedge clk); #1; n++; end
    chk({name, "_idle"}, 32'(busy), 0);
    chk({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic check_got(string name, int n, logic [23:0] exp);
    logic [23:0] act = 0;
    foreach (got[i]) act = {act[17:0], got[i]};
    chk({name, "_n"}, got.size(), n);
    chk(name, 32'(act), 32'(exp));
  endtask

  initial begin
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_rd_last", 32'(rd_last), 0);
    #9 rst = 1;
    rd_ready = 1;
    arm_t(2'd1, 6'd0);
    for (int i = 1; i <= 5; i++) retire(6'(i));
    wait_idle("m1");
    check_got("m1_order", 4, {6'd1, 6'd2, 6'd3, 6'd4});
    chk("m1_count", 32'(count), 4);
    chk("m1_ovf", 32'(overflow), 0);
    arm_t(2'd0, 6'd0);
    for (int i = 1; i <= 6; i++) retire(6'(i));
    stop_t();
    wait_idle("m0");
    check_got("m0_order", 4, {6'd3, 6'd4, 6'd5, 6'd6});
    chk("m0_ovf", 32'(overflow), 1);
    arm_t(2'd2, 6'd7);
    retire(6'd1); retire(6'd2); retire(6'd7); retire(6'd8);
    chk("m2_busy_after8", 32'(busy), 1);
    chk("m2_valid_after8", 32'(rd_valid), 0);
    retire(6'd9);
    wait_idle("m2");
    check_got("m2_order", 4, {6'd1, 6'd2, 6'd7, 6'd8});
    rd_ready = 0;
    arm_t(2'd1, 6'd0);
    for (int i = 11; i <= 14; i++) retire(6'(i));
    repeat (2) begin @(posedge clk); #1; end
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_data", 32'(rd_data), 32'(ent(6'd11)));
      chk("bp_hold_valid", 32'(rd_valid), 1);
    end
    rd_ready = 1;
    @(posedge clk); #1 rd_ready = 0;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold2_data", 32'(rd_data), 32'(ent(6'd12)));
      chk("bp_hold2_last", 32'(rd_last), 0);
    end
    rd_ready = 1;
    wait_idle("bp");
    check_got("bp_order", 4, {6'd11, 6'd12, 6'd13, 6'd14});
    arm_t(2'd0, 6'd0);
    stop_t();
    @(posedge clk); #1;
    chk("arm_stop_busy", 32'(busy), 0);
    check_got("arm_stop_none", 0, 24'd0);
    arm_t(2'd2, 6'd7);
    retire(6'd1);
    retire(6'd7, 1'b1);
    wait_idle("stop_trig");
    check_got("stop_trig_order", 2, {12'd0, 6'd1, 6'd7});
    chk("stop_trig_count", 32'(count), 2);
    rd_ready = 0;
    arm_t(2'd0, 6'd0);
    for (int i = 21; i <= 25; i++) retire(6'(i));
    stop_t();
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_rst_valid", 32'(rd_valid), 1);
    #2 rst = 0;
    mq.delete(); exp_q.delete(); got.delete(); m_ovf = 0; cap_on = 0;
    #1;
    chk("arst_valid", 32'(rd_valid), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_data", 32'(rd_data), 0);
    chk("arst_last", 32'(rd_last), 0);
    #3 rst = 1;
    rd_ready = 1;
    arm_t(2'd0, 6'd0);
    retire(6'd31); retire(6'd32);
    stop_t();
    wait_idle("post_rst");
    check_got("post_rst_order", 2, {12'd0, 6'd31, 6'd32});
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
